// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the dmem_lsu load/store unit.
// Byte lanes are little-endian: address bit 0 picks the high lane.
package dmem_lsu_pkg;

   localparam int N = 16;

   localparam logic SIZE_BYTE = 1'b0;
   localparam logic SIZE_HALF = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WRITE,
      RESP
   } lsu_state_t;

   function automatic logic [N-1:0] lane_extract(
      input logic [N-1:0] word,
      input logic         hiLane,
      input logic         isUnsigned
   );
      logic [7:0] lane;
      lane = hiLane ? word[15:8] : word[7:0];
      return isUnsigned ? {8'h00, lane} : {{8{lane[7]}}, lane};
   endfunction

endpackage

// File: rtl/dmem_lsu_merge.sv
// Byte-lane insert used by the read-modify-write path of byte stores.
module dmem_lsu_merge
   import dmem_lsu_pkg::*;
(
   input  logic [N-1:0] rdata_i,
   input  logic         hiLane_i,
   input  logic [7:0]   wbyte_i,
   output logic [N-1:0] merged_o
);

   always_comb begin
      merged_o = rdata_i;
      if (hiLane_i) merged_o[15:8] = wbyte_i;
      else          merged_o[7:0]  = wbyte_i;
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: one request at a time, byte/halfword loads with extension,
// byte stores via read-modify-write, misaligned halfword accesses flagged.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int n = 16
) (
   input  logic         clock,
   input  logic         nreset,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic         req_write,
   input  logic         req_size,
   input  logic         req_unsigned,
   input  logic [n-1:0] req_addr,
   input  logic [n-1:0] req_wdata,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [n-1:0] rsp_data,
   output logic         rsp_err,
   output logic         mem_write,
   output logic [n-1:0] mem_addr,
   output logic [n-1:0] mem_wdata,
   input  logic [n-1:0] mem_rdata
);

   lsu_state_t   state_q, state_d;
   logic         latWrite_q, latWrite_d;
   logic         latSize_q, latSize_d;
   logic         latUns_q, latUns_d;
   logic [n-1:0] latAddr_q, latAddr_d;
   logic [n-1:0] latWdata_q, latWdata_d;
   logic         err_q, err_d;
   logic [n-1:0] rdata_q, rdata_d;
   logic [n-1:0] merged_q, merged_d;
   logic [n-1:0] mergeOut;
   logic         unused_addr_msb;

   // The memory stride is four per halfword, so address bit 15 has no effect.
   assign mem_addr        = {latAddr_q[14:1], 2'b00};
   assign unused_addr_msb = latAddr_q[15];
   assign rsp_data        = rdata_q;
   assign rsp_err         = err_q;

   dmem_lsu_merge uMerge (
      .rdata_i  (mem_rdata),
      .hiLane_i (latAddr_q[0]),
      .wbyte_i  (latWdata_q[7:0]),
      .merged_o (mergeOut)
   );

   always_ff @(posedge clock or negedge nreset) begin
      if (!nreset) begin
         state_q    <= IDLE;
         latWrite_q <= 1'b0;
         latSize_q  <= SIZE_BYTE;
         latUns_q   <= 1'b0;
         latAddr_q  <= '0;
         latWdata_q <= '0;
         err_q      <= 1'b0;
         rdata_q    <= '0;
         merged_q   <= '0;
      end else begin
         state_q    <= state_d;
         latWrite_q <= latWrite_d;
         latSize_q  <= latSize_d;
         latUns_q   <= latUns_d;
         latAddr_q  <= latAddr_d;
         latWdata_q <= latWdata_d;
         err_q      <= err_d;
         rdata_q    <= rdata_d;
         merged_q   <= merged_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      latWrite_d = latWrite_q;
      latSize_d  = latSize_q;
      latUns_d   = latUns_q;
      latAddr_d  = latAddr_q;
      latWdata_d = latWdata_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      merged_d   = merged_q;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      mem_write  = 1'b0;
      mem_wdata  = '0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               latWrite_d = req_write;
               latSize_d  = req_size;
               latUns_d   = req_unsigned;
               latAddr_d  = req_addr;
               latWdata_d = req_wdata;
               rdata_d    = '0;
               err_d      = (req_size == SIZE_HALF) && req_addr[0];
               state_d    = ((req_size == SIZE_HALF) && req_addr[0]) ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            if (!latWrite_q) begin
               rdata_d = (latSize_q == SIZE_HALF) ? mem_rdata
                                                   : lane_extract(mem_rdata, latAddr_q[0], latUns_q);
               state_d = RESP;
            end else if (latSize_q == SIZE_HALF) begin
               mem_write = 1'b1;
               mem_wdata = latWdata_q;
               state_d   = RESP;
            end else begin
               merged_d = mergeOut;
               state_d  = WRITE;
            end
         end
         WRITE: begin
            mem_write = 1'b1;
            mem_wdata = merged_q;
            state_d   = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed scenarios plus randomized
// traffic checked against a word-level memory model.
module tb_dmem_lsu;

   logic        clock = 1'b0;
   logic        nreset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic        req_size = 1'b0;
   logic        req_unsigned = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [15:0] rsp_data;
   logic        rsp_err;
   logic        mem_write;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;

   int checks = 0;
   int failures = 0;

   // Harness memory: one halfword per mem_addr step of four.
   logic [15:0] hmem [0:16383];
   logic        memInit = 1'b0;

   int unsigned refMem [int unsigned];

   logic [15:0] rData;
   logic        rErr;
   int          lat;
   int          nWrites;
   logic [15:0] wAddr;
   logic [15:0] wData;

   int          expData;
   logic        expErr;
   int          expLat;
   int          expWrites;
   int          expWAddr;
   int          expWData;

   dmem_lsu dut (
      .clock        (clock),
      .nreset       (nreset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_err      (rsp_err),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   always #5 clock = ~clock;

   assign mem_rdata = hmem[mem_addr[15:2]];

   always @(posedge clock) begin
      if (memInit) begin
         for (int i = 0; i < 16384; i++) hmem[i] <= 16'h0000;
      end else if (mem_write) begin
         hmem[mem_addr[15:2]] <= mem_wdata;
      end
   end

   function automatic int unsigned refRead(input int unsigned key);
      return refMem.exists(key) ? refMem[key] : 0;
   endfunction

   // Reference model: computes the expected response, latency and memory write
   // from the request alone, and updates the model memory.
   task automatic modelOp(input logic w, input logic s, input logic u,
                          input logic [15:0] a, input logic [15:0] d);
      int unsigned key, word, lane, b;
      key       = (int'(a) % 32768) / 2;
      word      = refRead(key);
      expData   = 0;
      expErr    = 1'b0;
      expWrites = 0;
      expWAddr  = (key * 4) % 65536;
      expWData  = 0;
      if (s && (a % 2 == 1)) begin
         expErr = 1'b1;
         expLat = 1;
      end else if (!w) begin
         expLat = 2;
         if (s) expData = word;
         else begin
            lane    = (a % 2 == 1) ? word / 256 : word % 256;
            expData = (u || lane < 128) ? lane : lane + 65280;
         end
      end else if (s) begin
         expLat      = 2;
         expWrites   = 1;
         expWData    = d;
         refMem[key] = d;
      end else begin
         expLat      = 3;
         expWrites   = 1;
         b           = d % 256;
         expWData    = (a % 2 == 1) ? (word % 256) + b * 256 : (word / 256) * 256 + b;
         refMem[key] = expWData;
      end
   endtask

   // Drives one request from a cycle-aligned point and records what came back.
   task automatic doReq(input logic w, input logic s, input logic u,
                        input logic [15:0] a, input logic [15:0] d, input int hold);
      req_write    = w;
      req_size     = s;
      req_unsigned = u;
      req_addr     = a;
      req_wdata    = d;
      req_valid    = 1'b1;
      rsp_ready    = 1'b0;
      @(posedge clock); #1;
      req_valid = 1'b0;
      lat       = 1;
      nWrites   = 0;
      wAddr     = '0;
      wData     = '0;
      while (lat <= 10) begin
         if (mem_write) begin
            nWrites++;
            wAddr = mem_addr;
            wData = mem_wdata;
         end
         if (rsp_valid) break;
         @(posedge clock); #1;
         lat++;
      end
      rData = rsp_data;
      rErr  = rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(posedge clock); #1;
      end
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      nreset  = 1'b0;
      memInit = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      memInit = 1'b0;
      nreset  = 1'b1;
      @(posedge clock); #1;
      checks += 7;
      if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready); end
      if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
      if (rsp_data !== 16'h0) begin failures++; $display("[TB] FAIL reset_rsp_data: got %h expected 0000", rsp_data); end
      if (rsp_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_rsp_err: got %b expected 0", rsp_err); end
      if (mem_write !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_write: got %b expected 0", mem_write); end
      if (mem_addr !== 16'h0) begin failures++; $display("[TB] FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
      if (mem_wdata !== 16'h0) begin failures++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0000", mem_wdata); end
   endtask

   task automatic test_half_store_load();
      modelOp(1'b1, 1'b1, 1'b0, 16'h0004, 16'hBEEF);
      doReq(1'b1, 1'b1, 1'b0, 16'h0004, 16'hBEEF, 0);
      checks += 5;
      if (lat !== 2) begin failures++; $display("[TB] FAIL hst_latency: got %0d expected 2", lat); end
      if (nWrites !== 1) begin failures++; $display("[TB] FAIL hst_write_cycles: got %0d expected 1", nWrites); end
      if (wAddr !== 16'(expWAddr)) begin failures++; $display("[TB] FAIL hst_mem_addr: got %h expected %h", wAddr, 16'(expWAddr)); end
      if (wData !== 16'hBEEF) begin failures++; $display("[TB] FAIL hst_mem_wdata: got %h expected beef", wData); end
      if (rErr !== 1'b0 || rData !== 16'h0) begin failures++; $display("[TB] FAIL hst_rsp: got err=%b data=%h expected err=0 data=0000", rErr, rData); end
      modelOp(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0);
      doReq(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0, 1);
      checks += 4;
      if (rData !== 16'hBEEF) begin failures++; $display("[TB] FAIL hld_data: got %h expected beef", rData); end
      if (rErr !== 1'b0) begin failures++; $display("[TB] FAIL hld_err: got %b expected 0", rErr); end
      if (lat !== 2) begin failures++; $display("[TB] FAIL hld_latency: got %0d expected 2", lat); end
      if (nWrites !== 0) begin failures++; $display("[TB] FAIL hld_write_cycles: got %0d expected 0", nWrites); end
   endtask

   task automatic test_byte_store();
      modelOp(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0012);
      doReq(1'b1, 1'b0, 1'b0, 16'h0005, 16'h0012, 0);
      checks += 4;
      if (lat !== 3) begin failures++; $display("[TB] FAIL bst_latency: got %0d expected 3", lat); end
      if (nWrites !== 1) begin failures++; $display("[TB] FAIL bst_write_cycles: got %0d expected 1", nWrites); end
      if (wData !== 16'h12EF) begin failures++; $display("[TB] FAIL bst_mem_wdata: got %h expected 12ef", wData); end
      if (wAddr !== 16'(expWAddr)) begin failures++; $display("[TB] FAIL bst_mem_addr: got %h expected %h", wAddr, 16'(expWAddr)); end
      modelOp(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0);
      doReq(1'b0, 1'b1, 1'b0, 16'h0004, 16'h0, 0);
      checks++;
      if (rData !== 16'h12EF) begin failures++; $display("[TB] FAIL bst_readback: got %h expected 12ef", rData); end
   endtask

   task automatic test_byte_load();
      logic [15:0] addrs [3];
      logic        unsFlags [3];
      logic [15:0] wants [3];
      addrs = '{16'h0008, 16'h0008, 16'h0009};
      unsFlags = '{1'b0, 1'b1, 1'b0};
      wants = '{16'hFFF0, 16'h00F0, 16'hFF80};
      modelOp(1'b1, 1'b1, 1'b0, 16'h0008, 16'h80F0);
      doReq(1'b1, 1'b1, 1'b0, 16'h0008, 16'h80F0, 0);
      for (int i = 0; i < 3; i++) begin
         modelOp(1'b0, 1'b0, unsFlags[i], addrs[i], 16'h0);
         doReq(1'b0, 1'b0, unsFlags[i], addrs[i], 16'h0, 0);
         checks += 2;
         if (rData !== wants[i]) begin failures++; $display("[TB] FAIL bld_data_%0d: got %h expected %h", i, rData, wants[i]); end
         if (lat !== 2) begin failures++; $display("[TB] FAIL bld_latency_%0d: got %0d expected 2", i, lat); end
      end
   endtask

   task automatic test_misaligned();
      modelOp(1'b1, 1'b1, 1'b0, 16'h0003, 16'h5555);
      doReq(1'b1, 1'b1, 1'b0, 16'h0003, 16'h5555, 0);
      checks += 4;
      if (rErr !== 1'b1) begin failures++; $display("[TB] FAIL mis_err: got %b expected 1", rErr); end
      if (rData !== 16'h0) begin failures++; $display("[TB] FAIL mis_data: got %h expected 0000", rData); end
      if (lat !== 1) begin failures++; $display("[TB] FAIL mis_latency: got %0d expected 1", lat); end
      if (nWrites !== 0) begin failures++; $display("[TB] FAIL mis_write_cycles: got %0d expected 0", nWrites); end
      modelOp(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0);
      doReq(1'b0, 1'b1, 1'b0, 16'h0002, 16'h0, 0);
      checks += 2;
      if (rData !== 16'(expData)) begin failures++; $display("[TB] FAIL mis_memory_kept: got %h expected %h", rData, 16'(expData)); end
      if (rErr !== 1'b0) begin failures++; $display("[TB] FAIL mis_err_cleared: got %b expected 0", rErr); end
   endtask

   task automatic test_stall();
      modelOp(1'b1, 1'b0, 1'b0, 16'h0021, 16'h005A);
      req_write = 1'b1; req_size = 1'b0; req_unsigned = 1'b0;
      req_addr = 16'h0021; req_wdata = 16'h005A;
      req_valid = 1'b1;
      rsp_ready = 1'b0;
      @(posedge clock); #1;
      req_size  = 1'b1;
      req_addr  = 16'h0030;
      req_wdata = 16'hAAAA;
      for (int i = 0; i < 10 && !rsp_valid; i++) begin
         @(posedge clock); #1;
      end
      checks++;
      if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_rsp_arrives: got %b expected 1", rsp_valid); end
      for (int i = 0; i < 5; i++) begin
         checks += 3;
         if (rsp_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_rsp_valid_%0d: got %b expected 1", i, rsp_valid); end
         if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL stall_req_ready_%0d: got %b expected 0", i, req_ready); end
         if (mem_write !== 1'b0) begin failures++; $display("[TB] FAIL stall_mem_write_%0d: got %b expected 0", i, mem_write); end
         @(posedge clock); #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      checks += 2;
      if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL stall_release_ready: got %b expected 1", req_ready); end
      if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL stall_release_valid: got %b expected 0", rsp_valid); end
      modelOp(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0);
      doReq(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0, 0);
      checks++;
      if (rData !== 16'(expData)) begin failures++; $display("[TB] FAIL stall_ignored_req: got %h expected %h", rData, 16'(expData)); end
      modelOp(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0);
      doReq(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 0);
      checks++;
      if (rData !== 16'(expData)) begin failures++; $display("[TB] FAIL stall_store_data: got %h expected %h", rData, 16'(expData)); end
   endtask

   task automatic test_reset_midop();
      int unsigned oldWord;
      modelOp(1'b1, 1'b1, 1'b0, 16'h000C, 16'h1234);
      doReq(1'b1, 1'b1, 1'b0, 16'h000C, 16'h1234, 0);
      oldWord = refRead(6);
      req_write = 1'b1; req_size = 1'b0; req_unsigned = 1'b0;
      req_addr = 16'h000C; req_wdata = 16'h0077;
      req_valid = 1'b1;
      @(posedge clock); #1;
      req_valid = 1'b0;
      @(posedge clock); #1;
      checks += 2;
      if (mem_write !== 1'b1) begin failures++; $display("[TB] FAIL rmo_in_write: got %b expected 1", mem_write); end
      if (mem_wdata !== 16'h1277) begin failures++; $display("[TB] FAIL rmo_merged: got %h expected 1277", mem_wdata); end
      #2;
      nreset = 1'b0;
      #1;
      checks += 5;
      if (mem_write !== 1'b0) begin failures++; $display("[TB] FAIL rmo_write_drop: got %b expected 0", mem_write); end
      if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rmo_req_ready: got %b expected 1", req_ready); end
      if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rmo_rsp_valid: got %b expected 0", rsp_valid); end
      if (mem_addr !== 16'h0) begin failures++; $display("[TB] FAIL rmo_mem_addr: got %h expected 0000", mem_addr); end
      if (mem_wdata !== 16'h0) begin failures++; $display("[TB] FAIL rmo_mem_wdata: got %h expected 0000", mem_wdata); end
      @(posedge clock);
      @(negedge clock);
      nreset = 1'b1;
      @(posedge clock); #1;
      doReq(1'b0, 1'b1, 1'b0, 16'h000C, 16'h0, 0);
      checks++;
      if (rData !== 16'(oldWord)) begin failures++; $display("[TB] FAIL rmo_word_kept: got %h expected %h", rData, 16'(oldWord)); end
   endtask

   task automatic test_random();
      logic        w, s, u;
      logic [15:0] a, d;
      int          hold;
      for (int i = 0; i < 40; i++) begin
         w    = 1'($urandom_range(0, 1));
         s    = 1'($urandom_range(0, 1));
         u    = 1'($urandom_range(0, 1));
         a    = 16'($urandom_range(0, 63));
         a[15] = 1'($urandom_range(0, 1));
         d    = 16'($urandom);
         hold = $urandom_range(0, 2);
         modelOp(w, s, u, a, d);
         doReq(w, s, u, a, d, hold);
         checks += 4;
         if (rData !== 16'(expData)) begin failures++; $display("[TB] FAIL rnd_data_%0d: got %h expected %h", i, rData, 16'(expData)); end
         if (rErr !== expErr) begin failures++; $display("[TB] FAIL rnd_err_%0d: got %b expected %b", i, rErr, expErr); end
         if (lat !== expLat) begin failures++; $display("[TB] FAIL rnd_latency_%0d: got %0d expected %0d", i, lat, expLat); end
         if (nWrites !== expWrites) begin failures++; $display("[TB] FAIL rnd_writes_%0d: got %0d expected %0d", i, nWrites, expWrites); end
         if (expWrites == 1) begin
            checks += 2;
            if (wAddr !== 16'(expWAddr)) begin failures++; $display("[TB] FAIL rnd_waddr_%0d: got %h expected %h", i, wAddr, 16'(expWAddr)); end
            if (wData !== 16'(expWData)) begin failures++; $display("[TB] FAIL rnd_wdata_%0d: got %h expected %h", i, wData, 16'(expWData)); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_half_store_load();
      test_byte_store();
      test_byte_load();
      test_misaligned();
      test_stall();
      test_reset_midop();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
